// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO on the core data-memory port.
// Latency: register reads return one cycle after the address; a byte pushed into an idle, empty block starts on the next edge.
// Backpressure: none towards the core; a push into a full FIFO is dropped and latches a sticky overflow flag.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  input  logic [3:0]  we,
  output logic [31:0] r_data,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic       hit;
  logic [1:0] sel;
  logic       wr_en;

  assign hit   = (addr[31:4] == BASE_ADDR[31:4]);
  assign sel   = addr[3:2];
  assign wr_en = hit && (we != 4'd0);

  // Byte-offset bits and the upper data lanes carry no meaning in this map.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], w_data[31:16]};

  // ---------------------------------------------------------------------------
  // Control / configuration registers
  // ---------------------------------------------------------------------------
  logic        en_q, en_d;
  logic        irq_en_q, irq_en_d;
  logic [15:0] div_q, div_d;
  logic        ovf_q, ovf_d;

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push_req;
  logic          push;
  logic          pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign push_req   = wr_en && (sel == REG_TXDATA) && we[0];
  // A full FIFO still accepts a push when the serialiser drains an entry on the same edge.
  assign push       = push_req && (!fifo_full || pop);

  // ---------------------------------------------------------------------------
  // Transmit FSM state
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic [15:0] div_eff;
  logic [15:0] reload;

  // Divisor 0 behaves as 1; the reload always uses the divisor registered before this edge.
  assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
  assign reload  = div_eff - 16'd1;

  // Register writes: control, divisor lanes, sticky overflow set/clear.
  always_comb begin
    en_d     = en_q;
    irq_en_d = irq_en_q;
    div_d    = div_q;
    ovf_d    = ovf_q;
    if (wr_en && (sel == REG_STATUS) && we[0] && w_data[3]) begin
      ovf_d = 1'b0;
    end
    if (push_req && !push) begin
      ovf_d = 1'b1;
    end
    if (wr_en && (sel == REG_CTRL) && we[0]) begin
      en_d     = w_data[0];
      irq_en_d = w_data[1];
    end
    if (wr_en && (sel == REG_DIV)) begin
      if (we[0]) div_d[7:0]  = w_data[7:0];
      if (we[1]) div_d[15:8] = w_data[15:8];
    end
  end

  // Pointer and occupancy updates; pointers wrap naturally since the depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Serialiser next state: a frame is start bit, 8 data bits LSB first, stop bit, each DIV cycles.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_q && !fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem_q[rd_ptr_q];
          baud_d  = reload;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_q == 16'd0) begin
          baud_d    = reload;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (baud_q == 16'd0) begin
          baud_d  = reload;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_STOP: begin
        if (baud_q == 16'd0) begin
          // Chain straight into the next frame so queued bytes leave with no idle gap.
          if (en_q && !fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_mem_q[rd_ptr_q];
            baud_d  = reload;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
    endcase
  end

  // Line level derived from the next state so tx is a clean flop output.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [31:0] status_val;
  logic [31:0] rd_val;
  logic [31:0] r_data_q;
  logic [4:0]  count5;

  assign count5 = 5'(count_q);

  // STATUS image: occupancy, sticky overflow and live flags.
  always_comb begin
    status_val        = 32'd0;
    status_val[0]     = fifo_full;
    status_val[1]     = fifo_empty;
    status_val[2]     = (state_q != S_IDLE);
    status_val[3]     = ovf_q;
    status_val[12:8]  = count5;
  end

  // Read mux; misses and the write-only TXDATA return zero.
  always_comb begin
    rd_val = 32'd0;
    if (hit) begin
      case (sel)
        REG_TXDATA: rd_val = 32'd0;
        REG_STATUS: rd_val = status_val;
        REG_CTRL:   rd_val = {30'd0, irq_en_q, en_q};
        REG_DIV:    rd_val = {16'd0, div_q};
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------

  // FIFO payload: written only on accepted pushes, contents are don't-care until counted.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= w_data[7:0];
    end
  end

  // All control, FIFO bookkeeping, FSM and read-data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q      <= 1'b1;
      irq_en_q  <= 1'b0;
      div_q     <= 16'(CLK_DIV);
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      baud_q    <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      r_data_q  <= 32'd0;
    end else begin
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      div_q     <= div_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      r_data_q  <= rd_val;
    end
  end

  assign r_data = r_data_q;
  assign tx     = tx_q;
  assign irq    = irq_en_q && (count_q <= CW'(FIFO_DEPTH / 2));

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomised bench for uart_tx_mmio with a frame-level reference model.
// Latency: model predicts tx/irq/r_data for every cycle after reset.
// Backpressure: none; overflow behaviour is exercised by overfilling the FIFO.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 16;
  localparam int          CDIV  = 868;
  localparam logic [31:0] A_TX  = BASE + 32'h0;
  localparam logic [31:0] A_ST  = BASE + 32'h4;
  localparam logic [31:0] A_CT  = BASE + 32'h8;
  localparam logic [31:0] A_DV  = BASE + 32'hC;
  localparam logic [31:0] A_MISS = 32'h1000_0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'd0;
  logic [31:0] w_data = 32'd0;
  logic [3:0]  we = 4'd0;
  logic [31:0] r_data;
  logic        tx;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  uart_tx_mmio #(
    .BASE_ADDR (BASE),
    .CLK_DIV   (CDIV),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .w_data(w_data),
    .we    (we),
    .r_data(r_data),
    .tx    (tx),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: a byte queue plus the frame currently on the line,
  // described as ten bit slots of DIV cycles each.
  // ---------------------------------------------------------------------------
  logic [7:0]  m_q[$];
  bit          m_en = 1'b1;
  bit          m_ien = 1'b0;
  logic [15:0] m_div = 16'(CDIV);
  bit          m_ovf = 1'b0;
  bit          m_busy = 1'b0;
  logic [9:0]  m_frame = 10'h3FF;
  int          m_pos = 0;
  int          m_left = 0;
  logic [31:0] m_rdata = 32'd0;

  task automatic model_step();
    int  deff;
    int  n_old;
    bit  en_old;
    bit  start;
    bit  popped;
    bit  hit;
    int  sel;
    logic [7:0] b;
    deff   = (m_div == 16'd0) ? 1 : int'(m_div);
    n_old  = m_q.size();
    en_old = m_en;
    start  = 1'b0;
    popped = 1'b0;
    hit    = (addr[31:4] == BASE[31:4]);
    sel    = int'(addr[3:2]);
    // read sees the state before this edge
    if (!hit) m_rdata = 32'd0;
    else if (sel == 1)
      m_rdata = (n_old << 8) | (int'(m_ovf) << 3) | (int'(m_busy) << 2)
              | (int'(n_old == 0) << 1) | int'(n_old == DEPTH);
    else if (sel == 2) m_rdata = {30'd0, m_ien, m_en};
    else if (sel == 3) m_rdata = {16'd0, m_div};
    else m_rdata = 32'd0;
    // line timing
    if (m_busy) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_pos  = m_pos + 1;
        m_left = deff;
        if (m_pos == 10) begin
          if (en_old && n_old > 0) start = 1'b1;
          else m_busy = 1'b0;
        end
      end
    end else if (en_old && n_old > 0) begin
      start = 1'b1;
    end
    if (start) begin
      b       = m_q.pop_front();
      m_frame = {1'b1, b, 1'b0};
      m_pos   = 0;
      m_left  = deff;
      m_busy  = 1'b1;
      popped  = 1'b1;
    end
    // writes
    if (hit && we != 4'd0) begin
      case (sel)
        0: if (we[0]) begin
             if (n_old < DEPTH || popped) m_q.push_back(w_data[7:0]);
             else m_ovf = 1'b1;
           end
        1: if (we[0] && w_data[3]) m_ovf = 1'b0;
        2: if (we[0]) begin m_en = w_data[0]; m_ien = w_data[1]; end
        default: begin
          if (we[0]) m_div[7:0]  = w_data[7:0];
          if (we[1]) m_div[15:8] = w_data[15:8];
        end
      endcase
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_en = 1'b1; m_ien = 1'b0; m_div = 16'(CDIV); m_ovf = 1'b0;
      m_busy = 1'b0; m_pos = 0; m_left = 0; m_rdata = 32'd0;
    end else begin
      model_step();
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("tx", {31'd0, tx}, {31'd0, m_busy ? m_frame[m_pos] : 1'b1});
      cmp("irq", {31'd0, irq}, {31'd0, (m_ien && m_q.size() <= DEPTH / 2)});
      cmp("r_data", r_data, m_rdata);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: each starts at a negedge and returns at the next one.
  // ---------------------------------------------------------------------------
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] e);
    addr = a; w_data = d; we = e;
    @(negedge clk);
    we = 4'd0;
  endtask

  task automatic rd(input logic [31:0] a);
    addr = a; we = 4'd0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    we = 4'd0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    // reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;

    // reset values
    rd(A_ST); cmp("rst_status", r_data, 32'h0000_0002);
    rd(A_CT); cmp("rst_ctrl", r_data, 32'h0000_0001);
    rd(A_DV); cmp("rst_div", r_data, 32'd868);
    cmp("rst_tx", {31'd0, tx}, 32'd1);
    cmp("rst_irq", {31'd0, irq}, 32'd0);

    // single frame, DIV=4, byte 0x55 pushed at edge 0
    wr(A_DV, 32'd4, 4'h3);
    wr(A_TX, 32'h55, 4'h1);
    for (int i = 1; i <= 44; i++) begin
      @(negedge clk);
      if (i == 1)  cmp("f55_start_lo", {31'd0, tx}, 32'd0);
      if (i == 4)  cmp("f55_start_end", {31'd0, tx}, 32'd0);
      if (i == 5)  cmp("f55_bit0", {31'd0, tx}, 32'd1);
      if (i == 9)  cmp("f55_bit1", {31'd0, tx}, 32'd0);
      if (i == 36) cmp("f55_bit7", {31'd0, tx}, 32'd0);
      if (i == 37) cmp("f55_stop", {31'd0, tx}, 32'd1);
    end

    // back-to-back frames, DIV=2
    wr(A_DV, 32'd2, 4'h3);
    wr(A_TX, 32'hA5, 4'h1);
    wr(A_TX, 32'h3C, 4'h1);
    rd(A_ST); cmp("b2b_status1", r_data, 32'h0000_0104);
    idle(20);
    rd(A_ST); cmp("b2b_status2", r_data, 32'h0000_0006);
    idle(25);

    // overflow with enable off
    wr(A_CT, 32'd0, 4'h1);
    for (int i = 0; i < 17; i++) wr(A_TX, $urandom, 4'h1);
    rd(A_ST); cmp("ovf_status", r_data, 32'h0000_1009);
    wr(A_ST, 32'h8, 4'h1);
    rd(A_ST); cmp("ovf_clear", r_data, 32'h0000_1001);
    wr(A_CT, 32'd1, 4'h1);
    idle(16 * 20 + 10);
    rd(A_ST); cmp("drain_status", r_data, 32'h0000_0002);

    // irq threshold
    wr(A_CT, 32'd2, 4'h1);
    for (int i = 0; i < 9; i++) wr(A_TX, $urandom, 4'h1);
    idle(2);
    cmp("irq_9", {31'd0, irq}, 32'd0);
    wr(A_CT, 32'd3, 4'h1);
    idle(3);
    cmp("irq_8", {31'd0, irq}, 32'd1);
    idle(9 * 20);
    wr(A_CT, 32'd1, 4'h1);

    // reset during data bit 3 of a 0x00 frame
    wr(A_DV, 32'd4, 4'h3);
    wr(A_TX, 32'h00, 4'h1);
    repeat (17) @(negedge clk);
    cmp("pre_rst_tx", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("mid_rst_tx", {31'd0, tx}, 32'd1);
    rd(A_ST); cmp("mid_rst_status", r_data, 32'h0000_0002);
    wr(A_DV, 32'd4, 4'h3);
    wr(A_TX, 32'hC3, 4'h1);
    idle(45);

    // non-hit address
    rd(A_MISS); cmp("miss_read", r_data, 32'd0);
    wr(A_MISS, 32'hFFFF_FFFF, 4'hF);
    rd(A_CT); cmp("miss_ctrl", r_data, 32'd1);
    rd(A_DV); cmp("miss_div", r_data, 32'd4);

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      int unsigned k;
      int unsigned s;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  e;
      k = $urandom_range(0, 9);
      s = $urandom_range(0, 3);
      if (k == 0) a = A_MISS + $urandom_range(0, 255);
      else a = BASE + {28'd0, 2'(s), 2'b00} + $urandom_range(0, 3);
      e = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      d = $urandom;
      if (s == 3) d = $urandom_range(0, 5);
      if (s == 2) d = {30'd0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0)};
      if (s == 1) d = {28'd0, 1'($urandom_range(0, 1)), 3'd0};
      b = d[7:0];
      if (s == 0 && k != 0) d = {24'd0, b};
      addr = a; w_data = d; we = e;
      @(negedge clk);
    end
    idle(10);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the core's data-memory port; the core's load/store path initiates accesses and this block responds.
- Shares the RAM data-port signalling: address, 32-bit write data, 4-bit byte write enable, and read data registered one cycle later.
- Software writes bytes into a TX FIFO; an 8N1 serialiser drains the FIFO onto the tx pin.
- The SoC address decoder muxes r_data into the load path.

Parameters:
BASE_ADDR, 32'h1000_0000, register window base; bits [3:0] must be 0.
CLK_DIV, 868, reset value of the baud divisor, in clk cycles per bit.
FIFO_DEPTH, 16, TX FIFO entries; power of 2, minimum 2.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
addr  in  32  byte address from the core's memory-access controller
w_data  in  32  write data, lane-aligned
we  in  4  byte write enables; all zero means read
r_data  out  32  registered read data
tx  out  1  serial output; idles high
irq  out  1  level interrupt

Behaviour:
- Hit condition: addr[31:4] == BASE_ADDR[31:4]. Register select is addr[3:2]; addr[1:0] are ignored.
- Register map:
  - 0x0 TXDATA (W): write with we[0]=1 pushes w_data[7:0]. Reads return 0.
  - 0x4 STATUS (R):
    - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky).
    - bits[12:8] count, zero-extended.
    - Write with we[0]=1 and w_data[3]=1 clears overflow.
  - 0x8 CTRL (RW): bit0 enable (reset 1), bit1 irq_en (reset 0). Updated by we[0].
  - 0xC DIV (RW): bits[15:0] divisor (reset CLK_DIV[15:0]). Updated per byte lane by we[0]/we[1]. A value of 0 is treated as 1.
- Reads:
  - r_data is registered with one-cycle latency, matching RAM timing.
  - r_data = value selected by addr at edge k, visible after edge k.
  - r_data = 0 when the address is not a hit.
  - Reads have no side effects: the address is driven every cycle with no read strobe.
  - Reset value of r_data is 0.
- Writes:
  - Take effect at the edge where we != 0 and the address is a hit; misses are ignored.
  - If the FIFO is full with no same-cycle pop, a push is dropped and overflow is set.
  - If the FIFO is full and a pop occurs in the same cycle, the push is accepted and count stays at FIFO_DEPTH.
- FIFO: circular buffer with read/write pointers that wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. When enable=1 and FIFO non-empty, pop into the shift register, load the baud counter with DIV-1, and go to START.
  - START: tx=0 for DIV cycles.
  - DATA: 8 bits, LSB first, each held for DIV cycles. A 3-bit index tracks the bit position.
  - STOP: tx=1 for DIV cycles.
  - On STOP expiry: if enable=1 and FIFO non-empty, pop and go directly to START (back-to-back frames). Otherwise go to IDLE.
- Frame length is exactly 10*DIV cycles.
- Baud counter counts down to 0; the bit boundary occurs when it reaches 0, and it reloads with the current DIV-1.
  - A DIV write mid-frame takes effect at the next reload.
- Clearing enable mid-frame completes the current frame, then holds IDLE; FIFO contents are retained.
- Latency: a TXDATA write captured at edge k with FSM IDLE and FIFO empty produces the pop at edge k+1, and tx falls after edge k+1.
- irq = irq_en & (count <= FIFO_DEPTH/2), combinational from registered state.
- Reset values:
  - FIFO empty, pointers 0, overflow 0.
  - FSM IDLE, tx=1, r_data=0, irq=0.
- Reset mid-frame aborts the frame and tx returns to 1 after that edge. The same reset rule applies to reset mid-write.
- Simultaneous write to DIV and a bit boundary: the old DIV is used for that reload.

Test Plan:
- Reset, then read each register: STATUS after 1 cycle = 0x0000_0002 (empty), CTRL = 0x1, DIV = 868, tx=1, irq=0.
- DIV=4; write 0x55 to TXDATA at edge 0 -> tx low from edge 1 for 4 cycles, then bits 1,0,1,0,1,0,1,0 each for 4 cycles, then high 4 cycles. Busy clears at edge 41; empty stays 1 throughout.
- DIV=2; push 0xA5 then 0x3C on consecutive cycles -> two frames with no idle gap (40 cycles total). STATUS count reads 1 during frame 1 and 0 during frame 2.
- enable=0; push 17 bytes into FIFO_DEPTH=16 -> STATUS = full, count=16, overflow=1, tx stays 1. Write STATUS with 0x8 -> overflow=0. Set enable=1 -> 16 frames are sent, with bytes in push order.
- irq_en=1, enable=0, push 9 bytes -> irq=0. Set enable=1 -> irq rises when count drops to 8.
- Assert rst during DATA bit 3 of a frame -> after that edge tx=1, STATUS reads empty, and the next pushed byte is transmitted as a complete frame.
- Read at a non-hit address 0x1000_0010 -> r_data=0. Write there with we=4'hF -> no state change.
